// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared constants and types for the ID/EX pipeline register: opcodes, control
// bit positions, the EX control bundle and the bubble that replaces killed instructions.
package id_ex_pipeline_reg_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  // Bit positions within {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch}
  localparam int CNTL_REGWRITE = 5;
  localparam int CNTL_MEMREAD  = 4;
  localparam int CNTL_MEMWRITE = 3;
  localparam int CNTL_MEMTOREG = 2;
  localparam int CNTL_ALUSRC   = 1;
  localparam int CNTL_BRANCH   = 0;

  typedef struct packed {
    logic       valid;
    logic [5:0] cntl;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_ctrl_t;

  // A bubble looks like addi x0,x0,0 with every control bit clear
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    valid: 1'b0, cntl: 6'b0, opcode: OP_OPIMM, funct3: 3'b0,
    funct7b5: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
  };

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_STORE || op == OP_RTYPE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_loaduse_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is a
// source register actually read by the instruction in ID.
module id_loaduse_detect
  import id_ex_pipeline_reg_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
    rs2_hit = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
    hazard  = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use stall, WB-to-ID bypass, flush bubbles and
// memory-hold freeze. Define IDEX_PERF_COUNT_EN to build the stall/flush counters.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ID_Valid,
  input  logic [31:0]      ID_Instr,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [XLEN-1:0]  ID_ReadData1,
  input  logic [XLEN-1:0]  ID_ReadData2,
  input  logic [XLEN-1:0]  ID_Imm,
  input  logic [5:0]       ID_cntl,
  input  logic             WB_cntl_RegWrite,
  input  logic [4:0]       WB_WriteRegNum,
  input  logic [XLEN-1:0]  WB_WriteData,
  input  logic             EX_Flush,
  input  logic             MEM_Hold,
  output logic             Stall_ID,
  output logic             EX_Valid,
  output logic [6:0]       EX_opcode,
  output logic [2:0]       EX_funct3,
  output logic             EX_funct7b5,
  output logic [4:0]       EX_ReadRegNum1,
  output logic [4:0]       EX_ReadRegNum2,
  output logic [4:0]       EX_WriteRegNum,
  output logic [XLEN-1:0]  EX_PC,
  output logic [XLEN-1:0]  EX_ReadData1,
  output logic [XLEN-1:0]  EX_ReadData2,
  output logic [XLEN-1:0]  EX_Imm,
  output logic [5:0]       EX_cntl,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  ex_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            load_use;
  logic            wb_hit1;
  logic            wb_hit2;
  logic            instr_unused;

  assign id_rs1       = ID_Instr[19:15];
  assign id_rs2       = ID_Instr[24:20];
  assign instr_unused = ^{ID_Instr[31], ID_Instr[29:25]};

  id_loaduse_detect u_loaduse (
    .id_valid   (ID_Valid),
    .id_opcode  (ID_Instr[6:0]),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_valid   (ctrl_q.valid),
    .ex_memread (ctrl_q.cntl[CNTL_MEMREAD]),
    .ex_rd      (ctrl_q.rd),
    .hazard     (load_use)
  );

  // The register file is read before WB writes it, so a same-cycle write must bypass.
  assign wb_hit1 = WB_cntl_RegWrite && (WB_WriteRegNum != 5'd0) && (WB_WriteRegNum == id_rs1);
  assign wb_hit2 = WB_cntl_RegWrite && (WB_WriteRegNum != 5'd0) && (WB_WriteRegNum == id_rs2);

  always_comb begin
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    if (!MEM_Hold) begin
      if (EX_Flush || load_use || !ID_Valid) begin
        ctrl_d = EX_CTRL_BUBBLE;
        pc_d   = '0;
        rd1_d  = '0;
        rd2_d  = '0;
        imm_d  = '0;
      end else begin
        ctrl_d.valid    = 1'b1;
        ctrl_d.cntl     = ID_cntl;
        ctrl_d.opcode   = ID_Instr[6:0];
        ctrl_d.funct3   = ID_Instr[14:12];
        ctrl_d.funct7b5 = ID_Instr[30];
        ctrl_d.rs1      = id_rs1;
        ctrl_d.rs2      = id_rs2;
        ctrl_d.rd       = ID_Instr[11:7];
        pc_d            = ID_PC;
        rd1_d           = wb_hit1 ? WB_WriteData : ID_ReadData1;
        rd2_d           = wb_hit2 ? WB_WriteData : ID_ReadData2;
        imm_d           = ID_Imm;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
    end
  end

  assign Stall_ID       = load_use || MEM_Hold;
  assign EX_Valid       = ctrl_q.valid;
  assign EX_opcode      = ctrl_q.opcode;
  assign EX_funct3      = ctrl_q.funct3;
  assign EX_funct7b5    = ctrl_q.funct7b5;
  assign EX_ReadRegNum1 = ctrl_q.rs1;
  assign EX_ReadRegNum2 = ctrl_q.rs2;
  assign EX_WriteRegNum = ctrl_q.rd;
  assign EX_cntl        = ctrl_q.cntl;
  assign EX_PC          = pc_q;
  assign EX_ReadData1   = rd1_q;
  assign EX_ReadData2   = rd2_q;
  assign EX_Imm         = imm_q;

`ifdef IDEX_PERF_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && !MEM_Hold && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (EX_Flush && !MEM_Hold && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed, table-driven bench for id_ex_pipeline_reg: stalls, bypass, flush, hold,
// counters (expected only when IDEX_PERF_COUNT_EN is defined) and reset corners.
module tb_id_ex_pipeline_reg;

`ifdef IDEX_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] I_LW    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD   = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_LUI   = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_SW    = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] I_ADD3  = 32'h00318233; // add  x4,x3,x3
  localparam logic [31:0] I_ADD0  = 32'h00000233; // add  x4,x0,x0
  localparam logic [31:0] I_SUB   = 32'h40208433; // sub  x8,x1,x2
  localparam logic [5:0]  C_LW    = 6'b110110;
  localparam logic [5:0]  C_R     = 6'b100000;
  localparam logic [5:0]  C_LUI   = 6'b100010;
  localparam logic [5:0]  C_SW    = 6'b001010;
  localparam int K_B = 0, K_L = 1, K_H = 2;
  localparam logic [160:0] BUBBLE = {1'b0, 7'b0010011, 153'd0};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ID_Valid;
  logic [31:0] ID_Instr, ID_PC, ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [5:0]  ID_cntl;
  logic        WB_cntl_RegWrite;
  logic [4:0]  WB_WriteRegNum;
  logic [31:0] WB_WriteData;
  logic        EX_Flush, MEM_Hold;
  logic        Stall_ID, EX_Valid, EX_funct7b5;
  logic [6:0]  EX_opcode;
  logic [2:0]  EX_funct3;
  logic [4:0]  EX_ReadRegNum1, EX_ReadRegNum2, EX_WriteRegNum;
  logic [31:0] EX_PC, EX_ReadData1, EX_ReadData2, EX_Imm;
  logic [5:0]  EX_cntl;
  logic [31:0] StallCount, FlushCount;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .ID_Valid(ID_Valid), .ID_Instr(ID_Instr),
    .ID_PC(ID_PC), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_cntl(ID_cntl), .WB_cntl_RegWrite(WB_cntl_RegWrite),
    .WB_WriteRegNum(WB_WriteRegNum), .WB_WriteData(WB_WriteData),
    .EX_Flush(EX_Flush), .MEM_Hold(MEM_Hold), .Stall_ID(Stall_ID),
    .EX_Valid(EX_Valid), .EX_opcode(EX_opcode), .EX_funct3(EX_funct3),
    .EX_funct7b5(EX_funct7b5), .EX_ReadRegNum1(EX_ReadRegNum1),
    .EX_ReadRegNum2(EX_ReadRegNum2), .EX_WriteRegNum(EX_WriteRegNum),
    .EX_PC(EX_PC), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_cntl(EX_cntl), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc, rd1, rd2, imm;
    logic [5:0]  cntl;
    logic        wb_we;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        flush, hold;
    logic        exp_stall;
    int          kind;
    logic [31:0] exp_d1, exp_d2;
    int          exp_sc, exp_fc;
  } vec_t;

  vec_t vecs[22];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic v, logic [31:0] in, logic [31:0] pc, logic [31:0] r1,
                              logic [31:0] r2, logic [31:0] im, logic [5:0] c, logic we,
                              logic [4:0] wn, logic [31:0] wd, logic fl, logic ho,
                              logic es, int k, logic [31:0] e1, logic [31:0] e2,
                              int sc, int fc);
    vec_t r;
    r.valid = v; r.instr = in; r.pc = pc; r.rd1 = r1; r.rd2 = r2; r.imm = im; r.cntl = c;
    r.wb_we = we; r.wb_num = wn; r.wb_data = wd; r.flush = fl; r.hold = ho;
    r.exp_stall = es; r.kind = k; r.exp_d1 = e1; r.exp_d2 = e2; r.exp_sc = sc; r.exp_fc = fc;
    return r;
  endfunction

  function automatic logic [160:0] ex_bundle();
    return {EX_Valid, EX_opcode, EX_funct3, EX_funct7b5, EX_ReadRegNum1, EX_ReadRegNum2,
            EX_WriteRegNum, EX_cntl, EX_PC, EX_ReadData1, EX_ReadData2, EX_Imm};
  endfunction

  task automatic chk(input string name, input logic [160:0] act, input logic [160:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    ID_Valid = v.valid; ID_Instr = v.instr; ID_PC = v.pc; ID_ReadData1 = v.rd1;
    ID_ReadData2 = v.rd2; ID_Imm = v.imm; ID_cntl = v.cntl; WB_cntl_RegWrite = v.wb_we;
    WB_WriteRegNum = v.wb_num; WB_WriteData = v.wb_data; EX_Flush = v.flush; MEM_Hold = v.hold;
  endtask

  logic [160:0] exp_ex;
  vec_t         idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_B, 0, 0, 0, 0);
    vecs[0]  = mk(1, I_LW,  32'h100, 32'h11, 32'h22, 0, C_LW, 0, 0, 0, 0, 0, 0, K_L, 32'h11, 32'h22, 0, 0);
    vecs[1]  = mk(1, I_ADD, 32'h104, 32'h55, 32'h77, 0, C_R,  0, 0, 0, 0, 0, 1, K_B, 0, 0, 1, 0);
    vecs[2]  = mk(1, I_ADD, 32'h104, 32'h55, 32'h77, 0, C_R,  1, 5, 32'hCAFE, 0, 0, 0, K_L, 32'hCAFE, 32'h77, 1, 0);
    vecs[3]  = mk(1, I_LW,  32'h108, 32'h11, 32'h22, 0, C_LW, 0, 0, 0, 0, 0, 0, K_L, 32'h11, 32'h22, 1, 0);
    vecs[4]  = mk(1, I_LUI, 32'h10C, 32'hAA, 32'hBB, 32'h28000, C_LUI, 0, 0, 0, 0, 0, 0, K_L, 32'hAA, 32'hBB, 1, 0);
    vecs[5]  = mk(1, I_LW,  32'h110, 32'h11, 32'h22, 0, C_LW, 0, 0, 0, 0, 0, 0, K_L, 32'h11, 32'h22, 1, 0);
    vecs[6]  = mk(1, I_SW,  32'h114, 32'h2222, 32'h3333, 0, C_SW, 0, 0, 0, 0, 0, 1, K_B, 0, 0, 2, 0);
    vecs[7]  = mk(0, I_SW,  32'h114, 32'h2222, 32'h3333, 0, C_SW, 0, 0, 0, 0, 0, 0, K_B, 0, 0, 2, 0);
    vecs[8]  = mk(1, I_ADD3, 32'h118, 32'h1111, 32'h1111, 0, C_R, 1, 3, 32'hDEADBEEF, 0, 0, 0, K_L, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0);
    vecs[9]  = mk(1, I_ADD0, 32'h11C, 0, 0, 0, C_R, 1, 0, 32'h999, 0, 0, 0, K_L, 0, 0, 2, 0);
    vecs[10] = mk(1, I_SUB, 32'h120, 32'h5, 32'h3, 0, C_R, 0, 1, 32'h777, 0, 0, 0, K_L, 32'h5, 32'h3, 2, 0);
    vecs[11] = mk(1, I_LW,  32'h124, 32'h11, 32'h22, 0, C_LW, 0, 0, 0, 0, 0, 0, K_L, 32'h11, 32'h22, 2, 0);
    vecs[12] = mk(1, I_ADD, 32'h128, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 0, 1, 1, K_H, 0, 0, 2, 0);
    vecs[13] = mk(1, I_ADD, 32'h128, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 0, 1, 1, K_H, 0, 0, 2, 0);
    vecs[14] = mk(1, I_ADD, 32'h128, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 0, 1, 1, K_H, 0, 0, 2, 0);
    vecs[15] = mk(1, I_ADD, 32'h128, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 0, 0, 1, K_B, 0, 0, 3, 0);
    vecs[16] = mk(1, I_ADD, 32'h128, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 0, 0, 0, K_L, 32'h55, 32'h77, 3, 0);
    vecs[17] = mk(1, I_LW,  32'h12C, 32'h11, 32'h22, 0, C_LW, 0, 0, 0, 0, 0, 0, K_L, 32'h11, 32'h22, 3, 0);
    vecs[18] = mk(1, I_ADD, 32'h130, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 1, 1, 1, K_H, 0, 0, 3, 0);
    vecs[19] = mk(1, I_ADD, 32'h130, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 1, 0, 1, K_B, 0, 0, 4, 1);
    vecs[20] = mk(1, I_ADD, 32'h130, 32'h55, 32'h77, 0, C_R, 0, 0, 0, 0, 0, 0, K_L, 32'h55, 32'h77, 4, 1);
    vecs[21] = mk(1, I_SUB, 32'h134, 32'h5, 32'h3, 0, C_R, 0, 0, 0, 1, 0, 0, K_B, 0, 0, 4, 2);

    // Reset with no valid ID instruction
    drive(idle);
    reset_n = 1'b0;
    #12;
    chk("reset_ex", ex_bundle(), BUBBLE);
    chk("reset_stall", {160'd0, Stall_ID}, 161'd0);
    chk("reset_counts", {97'd0, StallCount, FlushCount}, 161'd0);
    MEM_Hold = 1'b1;
    #1;
    chk("reset_hold_stall", {160'd0, Stall_ID}, 161'd1);
    MEM_Hold = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ex", ex_bundle(), BUBBLE);
    $display("reset: ex=%h stall=%0b", ex_bundle(), Stall_ID);

    exp_ex = BUBBLE;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {160'd0, Stall_ID}, {160'd0, vecs[i].exp_stall});
      @(posedge clk); #1;
      if (vecs[i].kind == K_B) exp_ex = BUBBLE;
      else if (vecs[i].kind == K_L)
        exp_ex = {1'b1, vecs[i].instr[6:0], vecs[i].instr[14:12], vecs[i].instr[30],
                  vecs[i].instr[19:15], vecs[i].instr[24:20], vecs[i].instr[11:7],
                  vecs[i].cntl, vecs[i].pc, vecs[i].exp_d1, vecs[i].exp_d2, vecs[i].imm};
      chk($sformatf("v%0d_ex", i), ex_bundle(), exp_ex);
      chk($sformatf("v%0d_counts", i), {97'd0, StallCount, FlushCount},
          PERF ? {97'd0, 32'(vecs[i].exp_sc), 32'(vecs[i].exp_fc)} : 161'd0);
      $display("vec %0d: instr=%h stall=%0b ex_valid=%0b opcode=%h rd=%0d d1=%h d2=%h sc=%0d fc=%0d",
               i, vecs[i].instr, Stall_ID, EX_Valid, EX_opcode, EX_WriteRegNum,
               EX_ReadData1, EX_ReadData2, StallCount, FlushCount);
    end

    // Reset asserted in the middle of a load-use stall
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    #1;
    chk("midstall_pre", {160'd0, Stall_ID}, 161'd1);
    reset_n = 1'b0;
    #1;
    chk("midstall_stall", {160'd0, Stall_ID}, 161'd0);
    chk("midstall_ex", ex_bundle(), BUBBLE);
    chk("midstall_counts", {97'd0, StallCount, FlushCount}, 161'd0);
    MEM_Hold = 1'b1;
    #1;
    chk("midstall_hold", {160'd0, Stall_ID}, 161'd1);
    $display("reset mid-stall: ex=%h stall=%0b", ex_bundle(), Stall_ID);
    drive(idle);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", ex_bundle(), BUBBLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
